// File: rtl/uart_pkg.sv
// Shared types for the uart_tx arbiter: FSM state encoding and the header byte format
// used when UART_ARB_HDR_EN is defined.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        SEND = 2'd2,
        WAIT = 2'd3
    } arb_state_t;

    localparam logic [3:0] UART_HDR_TAG = 4'hA;

    // Header byte announcing which requester owns the packet that follows.
    function automatic logic [7:0] hdr_byte(input logic [3:0] idx);
        return {UART_HDR_TAG, idx};
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: grants the first set request strictly after rr_ptr,
// searching upward with wrap, so the previous owner has the lowest priority.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic               any
);

    int               idx;
    logic [PTR_W-1:0] sel;

    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = 0;
        sel   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            sel = PTR_W'(idx);
            if (!any && req[sel]) begin
                grant[sel] = 1'b1;
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one uart_tx between NUM_REQ byte streams.
// Define UART_ARB_HDR_EN to prefix every granted packet with a {4'hA, owner} header byte.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int MAX_PKT = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [8*NUM_REQ-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_last_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic                 tx_e_o,
    output logic [7:0]           tx_d_o,
    input  logic                 tx_busy_i
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_PKT + 1);

`ifdef UART_ARB_HDR_EN
    localparam arb_state_t FIRST_STATE = HDR;
`else
    localparam arb_state_t FIRST_STATE = SEND;
`endif

    arb_state_t         state_q, state_n;
    logic [NUM_REQ-1:0] grant_q, grant_n;
    logic [PTR_W-1:0]   gidx_q, gidx_n;
    logic [PTR_W-1:0]   rr_q, rr_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic               seen_q, seen_n;
    logic               last_q, last_n;
    logic               hdr_q, hdr_n;
    logic [NUM_REQ-1:0] ready_q, ready_n;
    logic               txe_q, txe_n;
    logic [7:0]         txd_q, txd_n;

    logic [NUM_REQ-1:0] pick_grant;
    logic               pick_any;
    logic [PTR_W-1:0]   pick_idx;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req    (req_valid_i),
        .rr_ptr (rr_q),
        .grant  (pick_grant),
        .any    (pick_any)
    );

    always_comb begin
        pick_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick_grant[k]) pick_idx = PTR_W'(k);
        end
    end

    always_comb begin
        state_n = state_q;
        grant_n = grant_q;
        gidx_n  = gidx_q;
        rr_n    = rr_q;
        cnt_n   = cnt_q;
        seen_n  = seen_q;
        last_n  = last_q;
        hdr_n   = hdr_q;
        ready_n = '0;
        txe_n   = 1'b0;
        txd_n   = txd_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_n = pick_grant;
                    gidx_n  = pick_idx;
                    state_n = FIRST_STATE;
                end
            end
`ifdef UART_ARB_HDR_EN
            HDR: begin
                if (!tx_busy_i) begin
                    txe_n   = 1'b1;
                    txd_n   = hdr_byte(4'(gidx_q));
                    seen_n  = 1'b0;
                    hdr_n   = 1'b1;
                    state_n = WAIT;
                end
            end
`endif
            SEND: begin
                if (req_valid_i[gidx_q] && !tx_busy_i) begin
                    txe_n           = 1'b1;
                    txd_n           = req_data_i[8*gidx_q +: 8];
                    ready_n[gidx_q] = 1'b1;
                    cnt_n           = cnt_q + CNT_W'(1);
                    last_n          = req_last_i[gidx_q];
                    seen_n          = 1'b0;
                    hdr_n           = 1'b0;
                    state_n         = WAIT;
                end
            end
            WAIT: begin
                // Only leave once the frame we strobed has been seen busy and then finished.
                if (tx_busy_i) seen_n = 1'b1;
                if (seen_q && !tx_busy_i) begin
                    if (hdr_q) begin
                        state_n = SEND;
                    end else if (last_q || cnt_q == CNT_W'(MAX_PKT)) begin
                        rr_n    = gidx_q;
                        grant_n = '0;
                        cnt_n   = '0;
                        state_n = IDLE;
                    end else begin
                        state_n = SEND;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= PTR_W'(NUM_REQ - 1);
            cnt_q   <= '0;
            seen_q  <= 1'b0;
            hdr_q   <= 1'b0;
            ready_q <= '0;
            txe_q   <= 1'b0;
            txd_q   <= '0;
        end else begin
            state_q <= state_n;
            grant_q <= grant_n;
            rr_q    <= rr_n;
            cnt_q   <= cnt_n;
            seen_q  <= seen_n;
            hdr_q   <= hdr_n;
            ready_q <= ready_n;
            txe_q   <= txe_n;
            txd_q   <= txd_n;
        end
    end

    // Owner index and last flag are only consulted while a grant is active.
    always_ff @(posedge clk) begin
        gidx_q <= gidx_n;
        last_q <= last_n;
    end

    assign req_ready_o = ready_q;
    assign grant_o     = grant_q;
    assign tx_e_o      = txe_q;
    assign tx_d_o      = txd_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a behavioural uart_tx, a serial line
// decoder and a queue-based packet round-robin reference model.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int MAX_PKT = 16;
    localparam int CPB     = 4;

    typedef struct {
        int         owner;
        bit         hdr;
        logic [7:0] data;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   grant;
    logic                 tx_e;
    logic [7:0]           tx_d;
    logic                 tx_busy = 1'b0;
    logic                 tx_line = 1'b1;

    int checks   = 0;
    int failures = 0;

    logic [8:0] dq [NUM_REQ][$];
    logic [8:0] mq [NUM_REQ][$];
    exp_t       exp_st[$];
    logic [7:0] exp_ser[$];
    int         mptr = NUM_REQ - 1;
    int         rdy_exp [NUM_REQ];
    int         rdy_cnt [NUM_REQ];
    bit         stall [NUM_REQ];
    bit         force_stall [NUM_REQ];
    bit         rand_stall_en = 1'b0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ (NUM_REQ),
        .MAX_PKT (MAX_PKT)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_last_i  (req_last),
        .req_ready_o (req_ready),
        .grant_o     (grant),
        .tx_e_o      (tx_e),
        .tx_d_o      (tx_d),
        .tx_busy_i   (tx_busy)
    );

    // Behavioural uart_tx: start bit, 8 data bits LSB first, stop bit, CPB clocks each.
    logic [9:0] frame;
    int         bit_idx = 0;
    int         clk_cnt = 0;
    always @(posedge clk) begin
        if (!tx_busy) begin
            if (tx_e) begin
                tx_busy <= 1'b1;
                frame   <= {1'b1, tx_d, 1'b0};
                tx_line <= 1'b0;
                bit_idx <= 0;
                clk_cnt <= 0;
            end
        end else if (clk_cnt == CPB - 1) begin
            clk_cnt <= 0;
            if (bit_idx == 9) begin
                tx_busy <= 1'b0;
                tx_line <= 1'b1;
            end else begin
                bit_idx <= bit_idx + 1;
                tx_line <= frame[bit_idx + 1];
            end
        end else begin
            clk_cnt <= clk_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Serial line monitor: decodes each frame at mid-bit and compares with the model.
    initial begin
        logic [7:0] b;
        logic       stop_bit;
        forever begin
            @(negedge tx_line);
            repeat (2) @(posedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(posedge clk);
                #1 b[i] = tx_line;
            end
            repeat (CPB) @(posedge clk);
            #1 stop_bit = tx_line;
            checks++;
            if (exp_ser.size() == 0) begin
                failures++;
                $display("FAIL serial_unexpected actual=%h required=none", b);
            end else begin
                logic [7:0] e;
                e = exp_ser.pop_front();
                if (b !== e || stop_bit !== 1'b1) begin
                    failures++;
                    $display("FAIL serial_byte actual=%h stop=%b required=%h stop=1", b, stop_bit, e);
                end
            end
        end
    end

    // Strobe monitor: every tx_e_o must match the next expected byte, owner and ready pulse.
    initial begin
        exp_t               e;
        logic [NUM_REQ-1:0] eg, er;
        forever begin
            @(posedge clk);
            #1;
            if (resetn === 1'b1 && (tx_e === 1'b1 || req_ready !== '0)) begin
                checks++;
                if (tx_e !== 1'b1) begin
                    failures++;
                    $display("FAIL ready_without_strobe actual=%b required=0", req_ready);
                end else if (exp_st.size() == 0) begin
                    failures++;
                    $display("FAIL strobe_unexpected actual=%h grant=%b required=none", tx_d, grant);
                end else begin
                    e  = exp_st.pop_front();
                    eg = NUM_REQ'(1 << e.owner);
                    er = e.hdr ? '0 : eg;
                    if (tx_d !== e.data || grant !== eg || req_ready !== er || tx_busy !== 1'b0) begin
                        failures++;
                        $display("FAIL strobe actual d=%h g=%b r=%b busy=%b required d=%h g=%b r=%b busy=0",
                                 tx_d, grant, req_ready, tx_busy, e.data, eg, er);
                    end
                    if (!e.hdr && req_ready[e.owner]) rdy_cnt[e.owner]++;
                end
            end
        end
    end

    // One clock of requester behaviour: consume on ready, present queue head, optional stalls.
    task automatic tick();
        bit has;
        @(negedge clk);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req_ready[k] && dq[k].size() > 0) void'(dq[k].pop_front());
            if (grant[k] && rand_stall_en) begin
                if ($urandom_range(0, 7) == 0) stall[k] = !stall[k];
            end else begin
                stall[k] = 1'b0;
            end
            has                = dq[k].size() > 0;
            req_valid[k]       = has && !stall[k] && !force_stall[k];
            req_data[8*k +: 8] = has ? dq[k][0][7:0] : 8'($urandom);
            req_last[k]        = has ? dq[k][0][8] : 1'($urandom);
        end
    endtask

    task automatic push(input int k, input logic [7:0] d, input bit last);
        dq[k].push_back({last, d});
        mq[k].push_back({last, d});
    endtask

    // Reference: repeatedly grant the first non-empty stream after the last owner and
    // take bytes until a last flag or MAX_PKT bytes.
    task automatic run_model();
        int         sel, n;
        bit         found;
        logic [8:0] e;
        forever begin
            found = 1'b0;
            sel   = 0;
            for (int i = 1; i <= NUM_REQ; i++) begin
                if (!found && mq[(mptr + i) % NUM_REQ].size() > 0) begin
                    found = 1'b1;
                    sel   = (mptr + i) % NUM_REQ;
                end
            end
            if (!found) break;
`ifdef UART_ARB_HDR_EN
            exp_st.push_back('{owner: sel, hdr: 1'b1, data: {4'hA, 4'(sel)}});
            exp_ser.push_back({4'hA, 4'(sel)});
`endif
            n = 0;
            do begin
                e = mq[sel].pop_front();
                exp_st.push_back('{owner: sel, hdr: 1'b0, data: e[7:0]});
                exp_ser.push_back(e[7:0]);
                rdy_exp[sel]++;
                n++;
            end while (!e[8] && n < MAX_PKT && mq[sel].size() > 0);
            mptr = sel;
        end
    endtask

    function automatic bit all_empty();
        for (int k = 0; k < NUM_REQ; k++) if (dq[k].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drain(input string name);
        int n = 0;
        while (!(all_empty() && exp_st.size() == 0 && exp_ser.size() == 0 &&
                 grant == '0 && !tx_busy) && n < 20000) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 20000) begin
            failures++;
            $display("FAIL %s_timeout actual=%0d pending required=0", name, exp_st.size());
            for (int k = 0; k < NUM_REQ; k++) dq[k].delete();
            exp_st.delete();
            exp_ser.delete();
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            chk($sformatf("%s_ready_count%0d", name, k), rdy_cnt[k], rdy_exp[k]);
            rdy_cnt[k] = 0;
            rdy_exp[k] = 0;
        end
    endtask

    initial begin
        int n;
        resetn    = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rdy_exp[k]     = 0;
            rdy_cnt[k]     = 0;
            stall[k]       = 1'b0;
            force_stall[k] = 1'b0;
        end
        repeat (3) tick();
        chk("reset_grant", grant, 0);
        chk("reset_ready", req_ready, 0);
        chk("reset_tx_e", tx_e, 0);
        chk("reset_tx_d", tx_d, 0);
        resetn = 1'b1;
        tick();

        // All four single-byte packets become valid together.
        for (int k = 0; k < NUM_REQ; k++) push(k, 8'(8'h10 + k), 1'b1);
        run_model();
        drain("simultaneous");

        push(0, 8'h55, 1'b0);
        push(0, 8'hA3, 1'b1);
        run_model();
        drain("two_byte");

        // Over-long packet forced off after MAX_PKT bytes while another requester waits.
        for (int i = 0; i < 20; i++) push(1, 8'(8'h80 + i), i == 19);
        push(2, 8'hC1, 1'b0);
        push(2, 8'hC2, 1'b1);
        run_model();
        drain("max_pkt");

        // Granted requester drops valid mid-packet; grant must be held with no strobes.
        for (int i = 0; i < 6; i++) push(0, 8'(8'h40 + i), i == 5);
        push(3, 8'h3F, 1'b1);
        run_model();
        n = 0;
        do begin
            tick();
            n++;
        end while (!req_ready[0] && n < 500);
        chk("stall_first_ready", {31'd0, req_ready[0]}, 1);
        force_stall[0] = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            chk("stall_grant", grant, 32'h1);
            chk("stall_tx_e", tx_e, 0);
        end
        force_stall[0] = 1'b0;
        drain("stall");

        push(2, 8'h7E, 1'b1);
        run_model();
        drain("single_7e");

        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int npk, len;
                npk = $urandom_range(0, 2);
                for (int p = 0; p < npk; p++) begin
                    len = $urandom_range(1, 20);
                    for (int b = 0; b < len; b++) push(k, 8'($urandom), b == len - 1);
                end
            end
            rand_stall_en = 1'b1;
            run_model();
            drain("random");
            rand_stall_en = 1'b0;
        end

        // Reset while waiting on the first frame of a packet.
        for (int i = 0; i < 3; i++) dq[0].push_back({i == 2, 8'(8'h60 + i)});
`ifdef UART_ARB_HDR_EN
        exp_st.push_back('{owner: 0, hdr: 1'b1, data: 8'hA0});
        exp_ser.push_back(8'hA0);
`else
        exp_st.push_back('{owner: 0, hdr: 1'b0, data: 8'h60});
        exp_ser.push_back(8'h60);
        rdy_exp[0] = 1;
`endif
        n = 0;
        do begin
            tick();
            n++;
        end while (!tx_e && n < 500);
        chk("abort_first_strobe", {31'd0, tx_e}, 1);
        repeat (3) tick();
        resetn = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) dq[k].delete();
        tick();
        chk("abort_grant", grant, 0);
        chk("abort_tx_e", tx_e, 0);
        chk("abort_ready", req_ready, 0);
        tick();
        resetn = 1'b1;
        mptr   = NUM_REQ - 1;
        push(3, 8'h3D, 1'b1);
        push(2, 8'h2C, 1'b1);
        run_model();
        n = 0;
        do begin
            tick();
            n++;
        end while (grant == '0 && n < 50);
        chk("post_reset_grant", grant, 32'h4);
        drain("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
